// File: rtl/ysyx_23060201_dmem.sv
// Data-memory responder: valid/ready request port, fixed-latency response port,
// word-organised storage with byte-lane stores and range/misalignment faults.
`timescale 1ns/1ps

module ysyx_23060201_dmem #(
  parameter int          DEPTH   = 1024,
  parameter logic [31:0] BASE    = 32'h8000_0000,
  parameter int          LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_wen,
  input  logic        mem_ren,
  input  logic [31:0] mem_waddr,
  input  logic [31:0] mem_raddr,
  input  logic [31:0] mem_wdata,
  input  logic [7:0]  mem_wmask,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [3:0]  LAT      = 4'(LATENCY);
  localparam logic [32:0] ADDR_END = {1'b0, BASE} + 33'(4 * DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        is_wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  mask;
  logic [31:0] mem [DEPTH];

  logic          accept, commit, rsp_done;
  logic          in_range, misalign, fault, wr_en;
  logic [1:0]    off;
  logic [7:0]    lanes;
  logic [31:0]   lane_data;
  logic [AW-1:0] idx;
  logic          unused_mask_hi;

  assign unused_mask_hi = ^mem_wmask[7:4];

  assign accept   = (state == IDLE) && req_valid && (mem_wen || mem_ren);
  assign commit   = (state == BUSY) && (cnt == LAT);
  assign rsp_done = (state == RESP) && rsp_ready;

  // 33-bit compare so addresses near the top of the space cannot wrap into range.
  assign in_range  = ({1'b0, addr} >= {1'b0, BASE}) && ({1'b0, addr} < ADDR_END);
  assign idx       = AW'((addr - BASE) >> 2);
  assign off       = addr[1:0];
  assign lanes     = {4'b0000, mask} << off;
  assign lane_data = wdata << {off, 3'b000};
  assign misalign  = is_wr && (|lanes[7:4]);
  assign fault     = !in_range || misalign;
  assign wr_en     = commit && is_wr && !fault;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)   state_nxt = BUSY;
      BUSY:    if (commit)   state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      is_wr <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      mask  <= '0;
    end else if (accept) begin
      cnt   <= 4'd1;
      is_wr <= mem_wen;
      addr  <= mem_wen ? mem_waddr : mem_raddr;
      wdata <= mem_wdata;
      mask  <= mem_wmask[3:0];
    end else if (commit) begin
      cnt <= '0;
    end else if (state == BUSY) begin
      cnt <= cnt + 4'd1;
    end
  end

  // NOTE: the storage array has no reset; its contents survive rst_n by design.
  // A reset forces state to IDLE, so wr_en cannot fire for an abandoned store.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (lanes[b]) mem[idx][8*b +: 8] <= lane_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_valid <= 1'b1;
      rsp_err   <= fault;
      rsp_rdata <= (is_wr || fault) ? '0 : mem[idx];
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_dmem.sv
// Self-checking bench for ysyx_23060201_dmem: directed plan plus randomized
// traffic compared against a byte-addressed reference memory.
`timescale 1ns/1ps

module tb_ysyx_23060201_dmem;

  localparam int          DEPTH   = 1024;
  localparam logic [31:0] BASE    = 32'h8000_0000;
  localparam int          LATENCY = 2;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        mem_wen;
  logic        mem_ren;
  logic [31:0] mem_waddr;
  logic [31:0] mem_raddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  logic [7:0] ref_mem [4*DEPTH];

  ysyx_23060201_dmem #(.DEPTH(DEPTH), .BASE(BASE), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .mem_wen   (mem_wen),
    .mem_ren   (mem_ren),
    .mem_waddr (mem_waddr),
    .mem_raddr (mem_raddr),
    .mem_wdata (mem_wdata),
    .mem_wmask (mem_wmask),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: a store writes byte b of wdata to address a+b for each
  // enabled mask bit, and faults if any of those bytes leaves the addressed word.
  function automatic void ref_access(input logic wen, input logic [31:0] a,
                                     input logic [31:0] d, input logic [7:0] m,
                                     output logic [31:0] rd, output logic err);
    longint ua  = {32'h0, a};
    longint lo  = {32'h0, BASE};
    longint hi  = lo + 4 * DEPTH;
    int     off = int'(a[1:0]);
    int     w;
    rd  = '0;
    err = (ua < lo) || (ua >= hi);
    if (wen) begin
      for (int b = 0; b < 4; b++) if (m[b] && (off + b > 3)) err = 1'b1;
      if (!err) begin
        for (int b = 0; b < 4; b++) if (m[b]) ref_mem[int'(ua - lo) + b] = d[8*b +: 8];
      end
    end else if (!err) begin
      w  = int'(ua - lo) & ~3;
      rd = {ref_mem[w+3], ref_mem[w+2], ref_mem[w+1], ref_mem[w]};
    end
  endfunction

  task automatic txn(input logic wen, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] m, input int hold, input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    ref_access(wen, a, d, m, exp_rd, exp_err);
    check({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    mem_wen   = wen;
    mem_ren   = !wen;
    mem_waddr = wen ? a : $urandom;
    mem_raddr = wen ? $urandom : a;
    mem_wdata = d;
    mem_wmask = m;
    @(posedge clk); #1;
    // Scramble the request inputs; the latched copy must be what gets used.
    req_valid = 1'b0;
    mem_wen   = 1'($urandom);
    mem_ren   = 1'($urandom);
    mem_waddr = $urandom;
    mem_raddr = $urandom;
    mem_wdata = $urandom;
    mem_wmask = 8'($urandom);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 20);
    check({tag, "/rsp_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "/latency"}, 32'(lat), 32'(LATENCY));
    check({tag, "/rdata"}, rsp_rdata, exp_rd);
    check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "/hold_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, "/hold_rdata"}, rsp_rdata, exp_rd);
      check({tag, "/hold_err"}, 32'(rsp_err), 32'(exp_err));
      check({tag, "/hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check({tag, "/done_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "/done_rdata"}, rsp_rdata, 32'd0);
    check({tag, "/done_err"}, 32'(rsp_err), 32'd0);
    check({tag, "/done_req_ready"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  m;
    int          r, word;

    for (int i = 0; i < 4*DEPTH; i++) ref_mem[i] = 8'h00;
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    mem_wen = 1'b0; mem_ren = 1'b0; mem_waddr = '0; mem_raddr = '0;
    mem_wdata = '0; mem_wmask = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset/rsp_rdata", rsp_rdata, 32'd0);
    check("reset/rsp_err", 32'(rsp_err), 32'd0);
    check("reset/req_ready", 32'(req_ready), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Known contents for the words the rest of the run reads back.
    for (int w = 0; w < 16; w++) txn(1'b1, BASE + 32'(4*w), 32'h0, 8'h0F, 0, "init_lo");
    for (int w = DEPTH-4; w < DEPTH; w++) txn(1'b1, BASE + 32'(4*w), 32'h0, 8'h0F, 0, "init_hi");

    txn(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F, 0, "sw_deadbeef");
    txn(1'b0, 32'h8000_0004, 32'h0, 8'h00, 0, "lw_deadbeef");
    txn(1'b1, 32'h8000_0005, 32'h0000_0012, 8'h01, 0, "sb_off1");
    txn(1'b0, 32'h8000_0004, 32'h0, 8'h00, 0, "lw_after_sb");
    txn(1'b1, 32'h8000_0007, 32'h0000_5566, 8'h03, 0, "sh_off3_err");
    txn(1'b0, 32'h8000_0004, 32'h0, 8'h00, 0, "lw_after_bad_sh");
    txn(1'b0, 32'h8000_0006, 32'h0, 8'h00, 0, "lw_misaligned_ok");
    txn(1'b0, 32'h7FFF_FFFC, 32'h0, 8'h00, 0, "lw_below_base");
    txn(1'b0, BASE + 32'(4*DEPTH), 32'h0, 8'h00, 0, "lw_past_end");
    txn(1'b1, 32'h7FFF_FFFC, 32'hAAAA_5555, 8'h0F, 0, "sw_below_base");
    txn(1'b1, BASE + 32'(4*DEPTH), 32'h5555_AAAA, 8'h0F, 0, "sw_past_end");
    txn(1'b0, BASE, 32'h0, 8'h00, 0, "lw_word0_no_alias");
    txn(1'b0, BASE + 32'(4*(DEPTH-1)), 32'h0, 8'h00, 0, "lw_last_no_alias");
    txn(1'b1, 32'h8000_0008, 32'h1234_5678, 8'hF0, 0, "store_mask_zero");
    txn(1'b0, 32'h8000_0008, 32'h0, 8'h00, 5, "lw_stall5");

    // A request with neither wen nor ren must be ignored.
    req_valid = 1'b1; mem_wen = 1'b0; mem_ren = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("ignored/req_ready", 32'(req_ready), 32'd1);
      check("ignored/rsp_valid", 32'(rsp_valid), 32'd0);
    end
    req_valid = 1'b0;
    repeat (LATENCY + 2) @(posedge clk);
    #1;
    check("ignored/no_rsp", 32'(rsp_valid), 32'd0);

    // Reset while a store is in flight: it must never commit.
    req_valid = 1'b1; mem_wen = 1'b1; mem_ren = 1'b0;
    mem_waddr = 32'h8000_0010; mem_wdata = 32'h1122_3344; mem_wmask = 8'h0F;
    @(posedge clk); #1;
    req_valid = 1'b0; mem_wen = 1'b0;
    check("midrst/busy_req_ready", 32'(req_ready), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("midrst/rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst/rsp_rdata", rsp_rdata, 32'd0);
    check("midrst/rsp_err", 32'(rsp_err), 32'd0);
    check("midrst/req_ready", 32'(req_ready), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h8000_0010, 32'h0, 8'h00, 0, "lw_after_midrst");

    for (int i = 0; i < 40; i++) begin
      r = int'($urandom_range(0, 9));
      if (r < 6) begin
        word = int'($urandom_range(0, 15));
        a = BASE + 32'(4*word) + 32'($urandom_range(0, 3));
      end else if (r < 8) begin
        word = int'($urandom_range(DEPTH-4, DEPTH-1));
        a = BASE + 32'(4*word) + 32'($urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 3))
          0:       a = BASE - 32'd4;
          1:       a = BASE + 32'(4*DEPTH);
          2:       a = 32'h0000_0000;
          default: a = 32'hFFFF_FFFC;
        endcase
      end
      case ($urandom_range(0, 4))
        0:       m = 8'h01;
        1:       m = 8'h03;
        2:       m = 8'h0F;
        3:       m = 8'h00;
        default: m = 8'($urandom);
      endcase
      txn(1'($urandom), a, $urandom, m, int'($urandom_range(0, 3)), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
